// File: rtl/clock_pkg.sv
// Shared encodings, range limits and calendar helper for the clock set front end.
package clock_pkg;

  typedef enum logic [1:0] {
    TGT_TIME  = 2'd0,
    TGT_DATE  = 2'd1,
    TGT_ALARM = 2'd2,
    TGT_TIMER = 2'd3
  } tgt_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EDIT   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  localparam logic [7:0] MAX_HOUR   = 8'd23;
  localparam logic [7:0] MAX_MINSEC = 8'd59;
  localparam logic [7:0] MAX_TMIN   = 8'd99;
  localparam logic [7:0] MAX_MONTH  = 8'd12;

  function automatic logic [7:0] days_in_month(input logic [7:0] month, input logic [15:0] year);
    logic leap;
    leap = ((year % 16'd4) == 16'd0) &&
           (((year % 16'd100) != 16'd0) || ((year % 16'd400) == 16'd0));
    case (month)
      8'd2:                    days_in_month = leap ? 8'd29 : 8'd28;
      8'd4, 8'd6, 8'd9, 8'd11: days_in_month = 8'd30;
      default:                 days_in_month = 8'd31;
    endcase
  endfunction

endpackage

// File: rtl/field_stepper.sv
// Combinational +/-1 step of one field with wrap at both ends; inc and dec together hold.
module field_stepper (
  input  logic [15:0] i_value,
  input  logic [15:0] i_min,
  input  logic [15:0] i_max,
  input  logic        i_inc,
  input  logic        i_dec,
  output logic [15:0] o_value
);

  // Boundary compare happens before the add so the result never overflows.
  always_comb begin
    o_value = i_value;
    if (i_inc && !i_dec) begin
      o_value = (i_value >= i_max) ? i_min : i_value + 16'd1;
    end else if (i_dec && !i_inc) begin
      o_value = (i_value <= i_min) ? i_max : i_value - 16'd1;
    end else begin
      o_value = i_value;
    end
  end

endmodule

// File: rtl/time_set_controller.sv
// Button-driven editor producing the time/date/alarm/timer set buses and one-cycle
// commit strobes for main_driver.
module time_set_controller
  import clock_pkg::*;
#(
  parameter logic [15:0] YEAR_MIN       = 16'd2000,
  parameter logic [15:0] YEAR_MAX       = 16'd2099,
  parameter int          TIMEOUT_CYCLES = 30,
  parameter int          TO_W           = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_next,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic        btn_confirm,
  input  logic [7:0]  current_24_hour,
  input  logic [7:0]  current_24_min,
  input  logic [7:0]  current_24_sec,
  input  logic [7:0]  current_day,
  input  logic [7:0]  current_month,
  input  logic [15:0] current_year,
  output logic [7:0]  input_hour,
  output logic [7:0]  input_min,
  output logic [7:0]  input_sec,
  output logic [7:0]  input_day,
  output logic [7:0]  input_month,
  output logic [15:0] input_year,
  output logic [7:0]  alarm_input_hour,
  output logic [7:0]  alarm_input_min,
  output logic [7:0]  alarm_input_sec,
  output logic [7:0]  timer_input_min,
  output logic [7:0]  timer_input_sec,
  output logic        set_time,
  output logic        set_date,
  output logic        set_alarm,
  output logic        set_timer,
  output logic        edit_active,
  output logic [1:0]  edit_target,
  output logic [1:0]  edit_field
);

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYCLES);

  state_e         r_state;
  tgt_e           r_target;
  logic [1:0]     r_field;
  logic           r_edit_active;
  logic [TO_W-1:0] r_to_cnt;
  // Working copy: a/b/c are hour/min/sec, day/month/-, or tmin/tsec/- by target.
  logic [7:0]     r_wk_a, r_wk_b, r_wk_c;
  logic [15:0]    r_wk_year;
  logic [7:0]     r_in_hour, r_in_min, r_in_sec, r_in_day, r_in_month;
  logic [15:0]    r_in_year;
  logic [7:0]     r_al_hour, r_al_min, r_al_sec, r_tm_min, r_tm_sec;
  logic           r_set_time, r_set_date, r_set_alarm, r_set_timer;

  logic [15:0]    w_fld_val, w_fld_min, w_fld_max, w_step;
  logic [7:0]     w_nxt_a, w_nxt_b, w_nxt_c, w_dim_new, w_day_clamped;
  logic [15:0]    w_nxt_year;
  logic [1:0]     w_last_field;
  logic           w_any_btn;

  assign w_any_btn    = btn_mode | btn_next | btn_inc | btn_dec | btn_confirm;
  assign w_last_field = (r_target == TGT_TIMER) ? 2'd1 : 2'd2;

  // Select the value and legal range of the field currently being edited.
  always_comb begin
    w_fld_val = 16'd0;
    w_fld_min = 16'd0;
    w_fld_max = 16'd0;
    case (r_target)
      TGT_DATE: begin
        case (r_field)
          2'd0:    begin w_fld_val = {8'd0, r_wk_a}; w_fld_min = 16'd1;
                         w_fld_max = {8'd0, days_in_month(r_wk_b, r_wk_year)}; end
          2'd1:    begin w_fld_val = {8'd0, r_wk_b}; w_fld_min = 16'd1;
                         w_fld_max = {8'd0, MAX_MONTH}; end
          default: begin w_fld_val = r_wk_year; w_fld_min = YEAR_MIN; w_fld_max = YEAR_MAX; end
        endcase
      end
      TGT_TIMER: begin
        case (r_field)
          2'd0:    begin w_fld_val = {8'd0, r_wk_a}; w_fld_max = {8'd0, MAX_TMIN}; end
          default: begin w_fld_val = {8'd0, r_wk_b}; w_fld_max = {8'd0, MAX_MINSEC}; end
        endcase
      end
      default: begin
        case (r_field)
          2'd0:    begin w_fld_val = {8'd0, r_wk_a}; w_fld_max = {8'd0, MAX_HOUR}; end
          2'd1:    begin w_fld_val = {8'd0, r_wk_b}; w_fld_max = {8'd0, MAX_MINSEC}; end
          default: begin w_fld_val = {8'd0, r_wk_c}; w_fld_max = {8'd0, MAX_MINSEC}; end
        endcase
      end
    endcase
  end

  field_stepper u_stepper (
    .i_value (w_fld_val),
    .i_min   (w_fld_min),
    .i_max   (w_fld_max),
    .i_inc   (btn_inc),
    .i_dec   (btn_dec),
    .o_value (w_step)
  );

  // Route the stepped value back into the working-copy slot it came from.
  always_comb begin
    w_nxt_a    = r_wk_a;
    w_nxt_b    = r_wk_b;
    w_nxt_c    = r_wk_c;
    w_nxt_year = r_wk_year;
    case (r_target)
      TGT_DATE: begin
        case (r_field)
          2'd0:    w_nxt_a    = w_step[7:0];
          2'd1:    w_nxt_b    = w_step[7:0];
          default: w_nxt_year = w_step;
        endcase
      end
      TGT_TIMER: begin
        case (r_field)
          2'd0:    w_nxt_a = w_step[7:0];
          default: w_nxt_b = w_step[7:0];
        endcase
      end
      default: begin
        case (r_field)
          2'd0:    w_nxt_a = w_step[7:0];
          2'd1:    w_nxt_b = w_step[7:0];
          default: w_nxt_c = w_step[7:0];
        endcase
      end
    endcase
  end

  // A month or year change pulls the day down to the new month length.
  assign w_dim_new     = days_in_month(w_nxt_b, w_nxt_year);
  assign w_day_clamped = (w_nxt_a > w_dim_new) ? w_dim_new : w_nxt_a;

  // Edit FSM, working copy, timeout and committed buses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_target      <= TGT_TIME;
      r_field       <= 2'd0;
      r_edit_active <= 1'b0;
      r_to_cnt      <= '0;
      r_wk_a        <= 8'd0;
      r_wk_b        <= 8'd0;
      r_wk_c        <= 8'd0;
      r_wk_year     <= 16'd0;
      r_in_hour     <= 8'd0;
      r_in_min      <= 8'd0;
      r_in_sec      <= 8'd0;
      r_in_day      <= 8'd1;
      r_in_month    <= 8'd1;
      r_in_year     <= YEAR_MIN;
      r_al_hour     <= 8'd0;
      r_al_min      <= 8'd0;
      r_al_sec      <= 8'd0;
      r_tm_min      <= 8'd0;
      r_tm_sec      <= 8'd0;
      r_set_time    <= 1'b0;
      r_set_date    <= 1'b0;
      r_set_alarm   <= 1'b0;
      r_set_timer   <= 1'b0;
    end else begin
      r_set_time  <= 1'b0;
      r_set_date  <= 1'b0;
      r_set_alarm <= 1'b0;
      r_set_timer <= 1'b0;
      if (w_any_btn) r_to_cnt <= '0;
      else if (r_to_cnt != TO_LIM) r_to_cnt <= r_to_cnt + 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (btn_mode) begin
            r_state       <= ST_EDIT;
            r_edit_active <= 1'b1;
            r_target      <= TGT_TIME;
            r_field       <= 2'd0;
            r_wk_a        <= current_24_hour;
            r_wk_b        <= current_24_min;
            r_wk_c        <= current_24_sec;
          end
        end
        ST_EDIT: begin
          if (btn_confirm) begin
            r_state       <= ST_COMMIT;
            r_edit_active <= 1'b0;
            case (r_target)
              TGT_TIME:  begin r_in_hour <= r_wk_a; r_in_min <= r_wk_b; r_in_sec <= r_wk_c;
                               r_set_time <= 1'b1; end
              TGT_DATE:  begin r_in_day <= r_wk_a; r_in_month <= r_wk_b; r_in_year <= r_wk_year;
                               r_set_date <= 1'b1; end
              TGT_ALARM: begin r_al_hour <= r_wk_a; r_al_min <= r_wk_b; r_al_sec <= r_wk_c;
                               r_set_alarm <= 1'b1; end
              default:   begin r_tm_min <= r_wk_a; r_tm_sec <= r_wk_b; r_set_timer <= 1'b1; end
            endcase
          end else if (btn_mode) begin
            r_field <= 2'd0;
            case (r_target)
              TGT_TIME:  begin r_target <= TGT_DATE; r_wk_a <= current_day;
                               r_wk_b <= current_month; r_wk_c <= 8'd0; r_wk_year <= current_year; end
              TGT_DATE:  begin r_target <= TGT_ALARM; r_wk_a <= r_al_hour;
                               r_wk_b <= r_al_min; r_wk_c <= r_al_sec; end
              TGT_ALARM: begin r_target <= TGT_TIMER; r_wk_a <= r_tm_min;
                               r_wk_b <= r_tm_sec; r_wk_c <= 8'd0; end
              default:   begin r_state <= ST_IDLE; r_target <= TGT_TIME; r_edit_active <= 1'b0; end
            endcase
          end else if (btn_next) begin
            r_field <= (r_field == w_last_field) ? 2'd0 : r_field + 2'd1;
          end else if (btn_inc || btn_dec) begin
            r_wk_a    <= (r_target == TGT_DATE) ? w_day_clamped : w_nxt_a;
            r_wk_b    <= w_nxt_b;
            r_wk_c    <= w_nxt_c;
            r_wk_year <= w_nxt_year;
          end else if (r_to_cnt == TO_LIM) begin
            r_state       <= ST_IDLE;
            r_edit_active <= 1'b0;
            r_target      <= TGT_TIME;
            r_field       <= 2'd0;
          end
        end
        ST_COMMIT: begin
          r_state  <= ST_IDLE;
          r_target <= TGT_TIME;
          r_field  <= 2'd0;
        end
        default: begin
          r_state       <= ST_IDLE;
          r_edit_active <= 1'b0;
          r_target      <= TGT_TIME;
          r_field       <= 2'd0;
        end
      endcase
    end
  end

  assign input_hour       = r_in_hour;
  assign input_min        = r_in_min;
  assign input_sec        = r_in_sec;
  assign input_day        = r_in_day;
  assign input_month      = r_in_month;
  assign input_year       = r_in_year;
  assign alarm_input_hour = r_al_hour;
  assign alarm_input_min  = r_al_min;
  assign alarm_input_sec  = r_al_sec;
  assign timer_input_min  = r_tm_min;
  assign timer_input_sec  = r_tm_sec;
  assign set_time         = r_set_time;
  assign set_date         = r_set_date;
  assign set_alarm        = r_set_alarm;
  assign set_timer        = r_set_timer;
  assign edit_active      = r_edit_active;
  assign edit_target      = r_target;
  assign edit_field       = r_field;

endmodule

// File: tb/tb_time_set_controller.sv
// Randomized bench for time_set_controller against a calendar-arithmetic model,
// with directed scenarios pinning hand-computed values.
module tb_time_set_controller;

  logic        clk = 1'b0;
  logic        reset, btn_mode, btn_next, btn_inc, btn_dec, btn_confirm;
  logic [7:0]  cur_h, cur_m, cur_s, cur_d, cur_mo;
  logic [15:0] cur_y;
  logic [7:0]  input_hour, input_min, input_sec, input_day, input_month;
  logic [15:0] input_year;
  logic [7:0]  alarm_input_hour, alarm_input_min, alarm_input_sec, timer_input_min, timer_input_sec;
  logic        set_time, set_date, set_alarm, set_timer, edit_active;
  logic [1:0]  edit_target, edit_field;

  always #5 clk = ~clk;

  time_set_controller dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_next(btn_next), .btn_inc(btn_inc),
    .btn_dec(btn_dec), .btn_confirm(btn_confirm),
    .current_24_hour(cur_h), .current_24_min(cur_m), .current_24_sec(cur_s),
    .current_day(cur_d), .current_month(cur_mo), .current_year(cur_y),
    .input_hour(input_hour), .input_min(input_min), .input_sec(input_sec),
    .input_day(input_day), .input_month(input_month), .input_year(input_year),
    .alarm_input_hour(alarm_input_hour), .alarm_input_min(alarm_input_min),
    .alarm_input_sec(alarm_input_sec), .timer_input_min(timer_input_min),
    .timer_input_sec(timer_input_sec), .set_time(set_time), .set_date(set_date),
    .set_alarm(set_alarm), .set_timer(set_timer), .edit_active(edit_active),
    .edit_target(edit_target), .edit_field(edit_field)
  );

  // Model: 0 idle, 1 edit, 2 commit; values held as plain integers.
  int m_st, m_tgt, m_fld, m_idle;
  int m_w[3];
  int m_wy;
  int m_ih, m_im, m_is, m_id, m_imo, m_iy, m_ah, m_am, m_as, m_tm, m_ts;
  int n_vec = 0;
  int n_err = 0;

  function automatic int dim(input int mo, input int y);
    int len[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    bit leap = (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
    return (mo == 2 && leap) ? 29 : len[mo - 1];
  endfunction

  function automatic int wrap(input int v, input int lo, input int hi, input int d);
    int n = hi - lo + 1;
    return lo + (((v - lo + d) % n) + n) % n;
  endfunction

  task automatic model_step(input bit r, input bit m, input bit n, input bit i, input bit d, input bit c);
    int dl = i ? 1 : -1;
    if (r) begin
      m_st = 0; m_tgt = 0; m_fld = 0; m_idle = 0;
      m_ih = 0; m_im = 0; m_is = 0; m_id = 1; m_imo = 1; m_iy = 2000;
      m_ah = 0; m_am = 0; m_as = 0; m_tm = 0; m_ts = 0;
      return;
    end
    if (m_st == 0) begin
      if (m) begin
        m_st = 1; m_tgt = 0; m_fld = 0; m_idle = 0;
        m_w[0] = cur_h; m_w[1] = cur_m; m_w[2] = cur_s;
      end
    end else if (m_st == 2) begin
      m_st = 0; m_tgt = 0; m_fld = 0;
    end else if (c) begin
      m_st = 2;
      if (m_tgt == 0) begin m_ih = m_w[0]; m_im = m_w[1]; m_is = m_w[2]; end
      else if (m_tgt == 1) begin m_id = m_w[0]; m_imo = m_w[1]; m_iy = m_wy; end
      else if (m_tgt == 2) begin m_ah = m_w[0]; m_am = m_w[1]; m_as = m_w[2]; end
      else begin m_tm = m_w[0]; m_ts = m_w[1]; end
    end else if (m) begin
      m_idle = 0; m_fld = 0;
      if (m_tgt == 3) begin m_st = 0; m_tgt = 0; end
      else begin
        m_tgt++;
        if (m_tgt == 1) begin m_w[0] = cur_d; m_w[1] = cur_mo; m_wy = cur_y; end
        else if (m_tgt == 2) begin m_w[0] = m_ah; m_w[1] = m_am; m_w[2] = m_as; end
        else begin m_w[0] = m_tm; m_w[1] = m_ts; end
      end
    end else if (n) begin
      m_idle = 0;
      m_fld = (m_fld + 1) % ((m_tgt == 3) ? 2 : 3);
    end else if (i || d) begin
      m_idle = 0;
      if (i != d) begin
        if (m_tgt == 1) begin
          if (m_fld == 0) m_w[0] = wrap(m_w[0], 1, dim(m_w[1], m_wy), dl);
          else if (m_fld == 1) m_w[1] = wrap(m_w[1], 1, 12, dl);
          else m_wy = wrap(m_wy, 2000, 2099, dl);
          if (m_w[0] > dim(m_w[1], m_wy)) m_w[0] = dim(m_w[1], m_wy);
        end else if (m_tgt == 3) m_w[m_fld] = wrap(m_w[m_fld], 0, (m_fld == 0) ? 99 : 59, dl);
        else m_w[m_fld] = wrap(m_w[m_fld], 0, (m_fld == 0) ? 23 : 59, dl);
      end
    end else if (m_idle == 30) begin
      m_st = 0; m_tgt = 0; m_fld = 0;
    end else m_idle++;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    n_vec++;
    chk("input_hour", input_hour, m_ih);   chk("input_min", input_min, m_im);
    chk("input_sec", input_sec, m_is);     chk("input_day", input_day, m_id);
    chk("input_month", input_month, m_imo); chk("input_year", input_year, m_iy);
    chk("alarm_hour", alarm_input_hour, m_ah); chk("alarm_min", alarm_input_min, m_am);
    chk("alarm_sec", alarm_input_sec, m_as); chk("timer_min", timer_input_min, m_tm);
    chk("timer_sec", timer_input_sec, m_ts);
    chk("set_time", set_time, int'(m_st == 2 && m_tgt == 0));
    chk("set_date", set_date, int'(m_st == 2 && m_tgt == 1));
    chk("set_alarm", set_alarm, int'(m_st == 2 && m_tgt == 2));
    chk("set_timer", set_timer, int'(m_st == 2 && m_tgt == 3));
    chk("edit_active", edit_active, int'(m_st == 1));
    chk("edit_target", edit_target, m_tgt);
    chk("edit_field", edit_field, m_fld);
  endtask

  task automatic step(input bit r, input bit m, input bit n, input bit i, input bit d, input bit c);
    reset = r; btn_mode = m; btn_next = n; btn_inc = i; btn_dec = d; btn_confirm = c;
    model_step(r, m, n, i, d, c);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle(input int k);
    for (int j = 0; j < k; j++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic set_live(input int h, input int mi, input int s, input int d, input int mo, input int y);
    cur_h = 8'(h); cur_m = 8'(mi); cur_s = 8'(s); cur_d = 8'(d); cur_mo = 8'(mo); cur_y = 16'(y);
  endtask

  initial begin
    set_live(10, 20, 30, 31, 1, 2020);
    step(1, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0);
    chk("reset_day", input_day, 1); chk("reset_year", input_year, 2000);
    chk("reset_active", edit_active, 0);
    // TIME edit 10:20:30 -> 12:19:30
    step(0, 1, 0, 0, 0, 0); step(0, 0, 0, 1, 0, 0); step(0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0, 0); step(0, 0, 0, 0, 1, 0); step(0, 0, 0, 0, 0, 1);
    chk("time_strobe", set_time, 1); chk("time_hour", input_hour, 12);
    chk("time_min", input_min, 19); chk("time_sec", input_sec, 30);
    idle(1);
    chk("time_strobe_off", set_time, 0); chk("time_exit", edit_active, 0);
    // DATE leap: 31/1/2020 -> month inc -> 29/2/2020
    step(0, 1, 0, 0, 0, 0); step(0, 1, 0, 0, 0, 0); step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0); step(0, 0, 0, 0, 0, 1);
    chk("leap_day", input_day, 29); chk("leap_month", input_month, 2); chk("leap_strobe", set_date, 1);
    idle(1);
    // DATE clamp: 29/2/2020, year inc -> 28/2/2021
    set_live(10, 20, 30, 29, 2, 2020);
    step(0, 1, 0, 0, 0, 0); step(0, 1, 0, 0, 0, 0); step(0, 0, 1, 0, 0, 0); step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("clamp_no_strobe", set_date, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("clamp_day", input_day, 28); chk("clamp_year", input_year, 2021);
    idle(1);
    // year wrap both ways
    set_live(0, 0, 0, 1, 1, 2000);
    step(0, 1, 0, 0, 0, 0); step(0, 1, 0, 0, 0, 0); step(0, 0, 1, 0, 0, 0); step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0); step(0, 0, 0, 0, 0, 1);
    chk("year_dec_wrap", input_year, 2099); idle(1);
    set_live(0, 0, 0, 1, 1, 2099);
    step(0, 1, 0, 0, 0, 0); step(0, 1, 0, 0, 0, 0); step(0, 0, 1, 0, 0, 0); step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0); step(0, 0, 0, 0, 0, 1);
    chk("year_inc_wrap", input_year, 2000); idle(1);
    // ALARM 00:00:30
    step(0, 1, 0, 0, 0, 0); step(0, 1, 0, 0, 0, 0); step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0); step(0, 0, 1, 0, 0, 0);
    for (int j = 0; j < 30; j++) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("alarm_strobe", set_alarm, 1); chk("alarm_sec_pin", alarm_input_sec, 30);
    chk("time_untouched", input_hour, 12);
    idle(1);
    // TIMER min dec at 0 -> 99
    for (int j = 0; j < 4; j++) step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0); step(0, 0, 0, 0, 0, 1);
    chk("timer_strobe", set_timer, 1); chk("timer_min_pin", timer_input_min, 99);
    idle(1);
    // timeout: still editing after 30 idle cycles, gone after 31
    step(0, 1, 0, 0, 0, 0); idle(30);
    chk("timeout_hold", edit_active, 1);
    idle(1);
    chk("timeout_exit", edit_active, 0);
    // mode from TIMER exits
    for (int j = 0; j < 5; j++) step(0, 1, 0, 0, 0, 0);
    chk("mode_exit", edit_active, 0);
    // reset one cycle before confirm
    step(0, 1, 0, 0, 0, 0); step(0, 0, 0, 1, 0, 0); step(1, 0, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 1);
    chk("reset_abort_strobe", set_time, 0); chk("reset_abort_hour", input_hour, 0);
    // confirm+inc uses pre-increment; inc+dec holds
    set_live(5, 6, 7, 1, 1, 2000);
    step(0, 1, 0, 0, 0, 0); step(0, 0, 0, 1, 0, 1);
    chk("confirm_beats_inc", input_hour, 5); idle(1);
    step(0, 1, 0, 0, 0, 0); step(0, 0, 0, 1, 1, 0); step(0, 0, 0, 0, 0, 1);
    chk("inc_dec_hold", input_hour, 5); idle(1);
    // random phase
    for (int k = 0; k < 4000; k++) begin
      int p = int'($urandom_range(0, 999));
      int yr = int'($urandom_range(2000, 2099));
      int mo = int'($urandom_range(1, 12));
      if ($urandom_range(0, 7) == 0)
        set_live(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)), int'($urandom_range(0, 59)),
                 int'($urandom_range(1, dim(mo, yr))), mo, yr);
      if (p < 3) step(1, 0, 0, 0, 0, 0);
      else if (p < 8) idle(32);
      else if (p < 450) step(0, 0, 0, 0, 0, 0);
      else if (p < 530) step(0, 1, 0, 0, 0, 0);
      else if (p < 630) step(0, 0, 1, 0, 0, 0);
      else if (p < 760) step(0, 0, 0, 1, 0, 0);
      else if (p < 880) step(0, 0, 0, 0, 1, 0);
      else if (p < 920) step(0, 0, 0, 0, 0, 1);
      else if (p < 950) step(0, 0, 0, 1, 1, 0);
      else if (p < 975) step(0, 0, 0, 1, 0, 1);
      else step(0, 1, 1, 0, 0, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
